// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer
//   Lets two requesters share one external 16-bit combinational adder.
//   A W-bit add/sub (W = 16*SLICES) is run as SLICES passes, LSB slice
//   first, with the carry registered between passes.
//
//   Optional feature macro: ADD_OVERFLOW_EN (adds the rsp_ovf port).
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid/ready           request handshake, N = 0,1 (ready is comb.)
//   reqN_a, reqN_b, reqN_sub   W-bit operands; sub=1 -> A-B
//   rsp_valid/ready            response handshake
//   rsp_id, rsp_sum, rsp_cout  owner, W-bit result, carry (NOT borrow on sub)
//   rsp_ovf                    signed overflow (ADD_OVERFLOW_EN only)
//   add_a, add_b, add_cin      shared adder inputs (zero outside RUN)
//   add_sum, add_cout          shared adder outputs
//   busy                       state != IDLE
module adder_slice_sequencer #(
  parameter int SLICES = 2,
  localparam int W = 16 * SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic [15:0]  add_a,
  output logic [15:0]  add_b,
  output logic         add_cin,
  input  logic [15:0]  add_sum,
  input  logic         add_cout,
`ifdef ADD_OVERFLOW_EN
  output logic         rsp_ovf,
`endif
  output logic         busy
);

  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Operands/results kept as an array of 16-bit slices so pass k indexes directly.
  typedef logic [SLICES-1:0][15:0] op_t;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;     // id granted most recently
  op_t           a_q, a_d;
  op_t           b_q, b_d;           // already inverted for sub
  logic          sub_q, sub_d;
  logic          id_q, id_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  op_t           res_q, res_d;
`ifdef ADD_OVERFLOW_EN
  logic          ovf_q, ovf_d;
`endif

  logic          is_idle, is_run;
  logic          gnt0, gnt1, accept;
  op_t           a_sel, b_sel;
  logic          sub_sel;

  assign is_idle = (state_q == S_IDLE);
  assign is_run  = (state_q == S_RUN);

  // Round-robin: on a tie the requester not granted last time wins.
  assign gnt0 = req0_valid & (~req1_valid |  last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  // Gated by rst_n so ready reads 0 while reset is asserted even if valid is high.
  assign req0_ready = rst_n & is_idle & gnt0;
  assign req1_ready = rst_n & is_idle & gnt1;
  assign accept     = req0_ready | req1_ready;

  assign a_sel   = gnt1 ? req1_a   : req0_a;
  assign b_sel   = gnt1 ? req1_b   : req0_b;
  assign sub_sel = gnt1 ? req1_sub : req0_sub;

  // Shared adder drive: quiet (all zero) unless a pass is in progress.
  assign add_a   = is_run ? a_q[k_q] : 16'h0000;
  assign add_b   = is_run ? b_q[k_q] : 16'h0000;
  assign add_cin = is_run & ((k_q == '0) ? sub_q : carry_q);

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = res_q;
  assign rsp_cout  = carry_q;
  assign busy      = ~is_idle;
`ifdef ADD_OVERFLOW_EN
  assign rsp_ovf   = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    id_d    = id_q;
    k_d     = k_q;
    carry_d = carry_q;
    res_d   = res_q;
`ifdef ADD_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = a_sel;
          b_d     = sub_sel ? ~b_sel : b_sel;
          sub_d   = sub_sel;
          id_d    = gnt1;
          last_d  = gnt1;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[k_q] = add_sum;
        carry_d    = add_cout;
        if (k_q == K_LAST) begin
          state_d = S_RESP;
`ifdef ADD_OVERFLOW_EN
          // Same-sign operands (post-inversion) producing a different-sign result.
          ovf_d = (a_q[SLICES-1][15] == b_q[SLICES-1][15]) &&
                  (add_sum[15] != a_q[SLICES-1][15]);
`endif
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;   // favour req0 on the first tie
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      id_q    <= 1'b0;
      k_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
`ifdef ADD_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      id_q    <= id_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      res_q   <= res_d;
`ifdef ADD_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_adder_slice_sequencer.sv
module tb_adder_slice_sequencer;
  localparam int SLICES = 2;
  localparam int W = 16 * SLICES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req0_ready, req0_sub = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic         req1_valid = 1'b0, req1_ready, req1_sub = 1'b0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;
  logic [15:0]  add_a, add_b, add_sum;
  logic         add_cin, add_cout, busy;
`ifdef ADD_OVERFLOW_EN
  logic         rsp_ovf;
`endif

  int    nchk = 0;
  int    nerr = 0;
  string cur = "init";

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};

  adder_slice_sequencer #(.SLICES(SLICES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
`ifdef ADD_OVERFLOW_EN
    .rsp_ovf(rsp_ovf),
`endif
    .busy(busy)
  );

  task automatic bad(input string name, input logic [63:0] obs, input logic [63:0] exp);
    nerr++;
    $error("FAIL %s/%s: observed %0h expected %0h", cur, name, obs, exp);
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  function automatic exp_t model(input logic id, input logic [W-1:0] a, b, input logic sub);
    exp_t   e;
    longint sa, sb, sr;
    e.id   = id;
    e.sum  = sub ? (a - b) : (a + b);
    e.cout = sub ? (a >= b) : ((65'(a) + 65'(b)) >= (65'(1) << W));
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    sr = sub ? (sa - sb) : (sa + sb);
    e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input exp_t e);
    nchk++; if (rsp_sum !== e.sum) bad("rsp_sum", rsp_sum, e.sum);
    nchk++; if (rsp_cout !== e.cout) bad("rsp_cout", rsp_cout, e.cout);
    nchk++; if (rsp_id !== e.id) bad("rsp_id", rsp_id, e.id);
`ifdef ADD_OVERFLOW_EN
    nchk++; if (rsp_ovf !== e.ovf) bad("rsp_ovf", rsp_ovf, e.ovf);
`endif
  endtask

  task automatic chk_quiet();
    nchk++; if (busy !== 1'b0) bad("busy0", busy, 0);
    nchk++; if (rsp_valid !== 1'b0) bad("rsp_valid0", rsp_valid, 0);
    nchk++; if (add_a !== 16'h0000) bad("add_a0", add_a, 0);
    nchk++; if (add_b !== 16'h0000) bad("add_b0", add_b, 0);
    nchk++; if (add_cin !== 1'b0) bad("add_cin0", add_cin, 0);
  endtask

  task automatic issue(input logic id, input logic [W-1:0] a, b, input logic sub);
    logic [W-1:0] beff;
    logic         rdy;
    int           n;
    beff = sub ? ~b : b;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    #1;
    n = 0;
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(posedge clk); #2;
      rdy = id ? req1_ready : req0_ready;
      n++;
    end
    nchk++; if (rdy !== 1'b1) bad("ready", rdy, 1);
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    nchk++; if (busy !== 1'b1) bad("busy", busy, 1);
    nchk++; if (add_a !== a[15:0]) bad("add_a_k0", add_a, a[15:0]);
    nchk++; if (add_b !== beff[15:0]) bad("add_b_k0", add_b, beff[15:0]);
    nchk++; if (add_cin !== sub) bad("add_cin_k0", add_cin, sub);
  endtask

  task automatic wait_rsp();
    int n;
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    nchk++; if (n != SLICES + 1) bad("latency", n, SLICES + 1);
  endtask

  task automatic run_op(input logic id, input logic [W-1:0] a, b, input logic sub);
    exp_t e;
    e = model(id, a, b, sub);
    issue(id, a, b, sub);
    wait_rsp();
    chk_rsp(e);
    tick();
    chk_quiet();
  endtask

  initial begin : main
    exp_t         e, got;
    exp_t         sb[$];
    logic [W-1:0] a, b;
    logic         id, sub, g0, g1;
    int           grants, cnt0, cnt1;

    cur = "reset";
    req0_valid = 1'b1;
    #2;
    chk_quiet();
    nchk++; if (req0_ready !== 1'b0) bad("req0_ready", req0_ready, 0);
    nchk++; if (rsp_sum !== 32'h0) bad("rsp_sum", rsp_sum, 0);
    nchk++; if (rsp_cout !== 1'b0) bad("rsp_cout", rsp_cout, 0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    cur = "t1";
    run_op(1'b0, 32'h0001_FFFF, 32'h0000_0001, 1'b0);
    cur = "t2";
    run_op(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1);
    cur = "t5";
    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    cur = "wrap_add";
    run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    cur = "sub_eq";
    run_op(1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1);
    cur = "sub_ovf";
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1);

    for (int i = 0; i < 12; i++) begin
      cur = $sformatf("rand%0d", i);
      id  = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i % 4 == 0) ? a : $urandom;
      run_op(id, a, b, sub);
    end

    cur = "t4";
    rsp_ready = 1'b0;
    e = model(1'b0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    issue(1'b0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    wait_rsp();
    req1_valid = 1'b1; req1_a = 32'h0000_0005; req1_b = 32'h0000_0007; req1_sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      nchk++; if (rsp_valid !== 1'b1) bad("hold_valid", rsp_valid, 1);
      nchk++; if (rsp_sum !== e.sum) bad("hold_sum", rsp_sum, e.sum);
      nchk++; if (req1_ready !== 1'b0) bad("no_accept", req1_ready, 0);
      tick();
    end
    chk_rsp(e);
    rsp_ready = 1'b1;
    #1;
    nchk++; if (req1_ready !== 1'b0) bad("no_accept_exit", req1_ready, 0);
    tick();
    #1;
    nchk++; if (rsp_valid !== 1'b0) bad("rsp_dropped", rsp_valid, 0);
    nchk++; if (req1_ready !== 1'b1) bad("next_accept", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    e = model(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1);
    wait_rsp();
    chk_rsp(e);
    tick();

    cur = "t6";
    issue(1'b1, 32'hAAAA_5555, 32'h1111_2222, 1'b0);
    tick();
    req0_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet();
    nchk++; if (req0_ready !== 1'b0) bad("req0_ready", req0_ready, 0);
    nchk++; if (req1_ready !== 1'b0) bad("req1_ready", req1_ready, 0);
    nchk++; if (rsp_sum !== 32'h0) bad("rsp_sum", rsp_sum, 0);
    nchk++; if (rsp_id !== 1'b0) bad("rsp_id", rsp_id, 0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nchk++; if (rsp_valid !== 1'b0) bad("no_stale", rsp_valid, 0);
      tick();
    end
    run_op(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);

    cur = "t3";
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom_range(0, 1));
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom_range(0, 1));
    grants = 0; cnt0 = 0; cnt1 = 0;
    for (int cyc = 0; cyc < 200 && (grants < 8 || sb.size() > 0); cyc++) begin
      #1;
      if (rsp_valid) begin
        nchk++; if (sb.size() == 0) bad("sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk_rsp(got);
        end
      end
      g0 = req0_ready;
      g1 = req1_ready;
      nchk++; if ((g0 & g1) !== 1'b0) bad("onehot", g0 & g1, 0);
      if (g0 | g1) begin
        nchk++; if (g1 !== 1'(grants % 2)) bad("rr_order", g1, grants % 2);
        if (g1) sb.push_back(model(1'b1, req1_a, req1_b, req1_sub));
        else    sb.push_back(model(1'b0, req0_a, req0_b, req0_sub));
        grants++;
      end
      tick();
      if (g0) begin
        cnt0++;
        if (cnt0 == 4) req0_valid = 1'b0;
        else begin req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom_range(0, 1)); end
      end
      if (g1) begin
        cnt1++;
        if (cnt1 == 4) req1_valid = 1'b0;
        else begin req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom_range(0, 1)); end
      end
    end
    nchk++; if (grants != 8) bad("grants", grants, 8);
    nchk++; if (sb.size() != 0) bad("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
